val2_shift_sequencer: RTL and testbench

Multi-cycle operand-2 generator for the execute stage. It captures an ARM shifter operand (register shift, rotated 8-bit immediate, or 12-bit load/store offset) on a start pulse, and applies the shift or rotate at SHIFT_PER_CYCLE bit positions per clock. It holds the pipeline stalled through `busy` and delivers the result with a one-cycle `done` pulse. This replaces a single-cycle barrel shift on the critical path and sits between the register-read stage and the ALU operand mux.

---
 rtl/val2_shift_sequencer.sv | 137 +++++++++++++
 tb/tb_val2_shift_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle ARM operand-2 shifter: captures the shifter operand on start and
// walks the shift SHIFT_PER_CYCLE positions per clock, stalling via busy.
module val2_shift_sequencer #(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] val_rm,
    input  logic [11:0] shift_operand,
    input  logic        imm,
    input  logic        ldr_or_str,
    output logic        busy,
    output logic        done,
    output logic [31:0] val2
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;
    localparam logic [4:0] K   = 5'(SHIFT_PER_CYCLE);

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  rem_q, rem_d;
    logic [1:0]  type_q, type_d;
    logic [31:0] val2_q, val2_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] cap_val;
    logic [4:0]  cap_amt;
    logic [1:0]  cap_ty;
    logic [4:0]  step;
    logic [31:0] shifted;

    // Operand decode: memory offset beats immediate beats register shift.
    always_comb begin
        cap_val = val_rm;
        cap_amt = shift_operand[11:7];
        cap_ty  = shift_operand[6:5];
        if (ldr_or_str) begin
            cap_val = {{20{shift_operand[11]}}, shift_operand};
            cap_amt = 5'd0;
            cap_ty  = LSL;
        end else if (imm) begin
            cap_val = {24'b0, shift_operand[7:0]};
            cap_amt = {shift_operand[11:8], 1'b0};
            cap_ty  = ROR;
        end
    end

    always_comb begin
        step = (rem_q < K) ? rem_q : K;
        case (type_q)
            LSL:     shifted = work_q << step;
            LSR:     shifted = work_q >> step;
            ASR:     shifted = $unsigned($signed(work_q) >>> step);
            default: shifted = (work_q >> step) | (work_q << (6'd32 - {1'b0, step}));
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        type_d  = type_q;
        val2_d  = val2_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            work_d  = '0;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start) begin
                        type_d = cap_ty;
                        if (cap_amt == 5'd0) begin
                            val2_d  = cap_val;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            work_d  = cap_val;
                            rem_d   = cap_amt;
                            state_d = SHIFT;
                            busy_d  = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work_d = shifted;
                    rem_d  = rem_q - step;
                    if (rem_q == step) begin
                        val2_d  = shifted;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            type_q  <= LSL;
            val2_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            type_q  <= type_d;
            val2_q  <= val2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign val2 = val2_q;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Bench for val2_shift_sequencer: K=1 and K=4 instances share stimulus and are
// compared every cycle against a latency/result model, plus directed cases.
module tb_val2_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush, imm, ldr_or_str;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic        busy1, done1, busy4, done4;
    logic [31:0] val21, val24;

    int n_chk = 0;
    int n_fail = 0;

    localparam int KS [2] = '{1, 4};

    always #5 clk = ~clk;

    val2_shift_sequencer #(.SHIFT_PER_CYCLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .val_rm(val_rm),
        .shift_operand(shift_operand), .imm(imm), .ldr_or_str(ldr_or_str),
        .busy(busy1), .done(done1), .val2(val21));

    val2_shift_sequencer #(.SHIFT_PER_CYCLE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .val_rm(val_rm),
        .shift_operand(shift_operand), .imm(imm), .ldr_or_str(ldr_or_str),
        .busy(busy4), .done(done4), .val2(val24));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int ref_amt(input logic [11:0] op, input logic im, input logic ls);
        if (ls) return 0;
        if (im) return 2 * int'(op[11:8]);
        return int'(op[11:7]);
    endfunction

    function automatic logic [31:0] ref_val(input logic [31:0] rm, input logic [11:0] op,
                                            input logic im, input logic ls);
        logic [31:0] v;
        logic [63:0] dbl;
        int a, ty;
        a = ref_amt(op, im, ls);
        if (ls) return {{20{op[11]}}, op};
        if (im) begin v = {24'b0, op[7:0]}; ty = 3; end
        else begin v = rm; ty = int'(op[6:5]); end
        case (ty)
            0: return v << a;
            1: return v >> a;
            2: return v[31] ? ~((~v) >> a) : (v >> a);
            default: begin dbl = {v, v} >> a; return dbl[31:0]; end
        endcase
    endfunction

    // Model: cycles left in the stall, pending result, done flag, last result.
    int          left [2] = '{0, 0};
    logic [31:0] pend [2] = '{32'h0, 32'h0};
    logic [31:0] mval2[2] = '{32'h0, 32'h0};
    logic        mdone[2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                left[i] <= 0; pend[i] <= '0; mval2[i] <= '0; mdone[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int c;
                c = (ref_amt(shift_operand, imm, ldr_or_str) + KS[i] - 1) / KS[i];
                if (flush) begin
                    left[i] <= 0; mdone[i] <= 1'b0;
                end else if (left[i] > 0) begin
                    left[i]  <= left[i] - 1;
                    mdone[i] <= (left[i] == 1);
                    if (left[i] == 1) mval2[i] <= pend[i];
                end else if (start) begin
                    if (c == 0) begin
                        mdone[i] <= 1'b1;
                        mval2[i] <= ref_val(val_rm, shift_operand, imm, ldr_or_str);
                    end else begin
                        left[i]  <= c;
                        pend[i]  <= ref_val(val_rm, shift_operand, imm, ldr_or_str);
                        mdone[i] <= 1'b0;
                    end
                end else begin
                    mdone[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("k1_busy", {31'b0, busy1}, {31'b0, left[0] > 0});
        chk("k1_done", {31'b0, done1}, {31'b0, mdone[0]});
        chk("k1_val2", val21, mval2[0]);
        chk("k4_busy", {31'b0, busy4}, {31'b0, left[1] > 0});
        chk("k4_done", {31'b0, done4}, {31'b0, mdone[1]});
        chk("k4_val2", val24, mval2[1]);
        if (busy1 && done1) chk("k1_busy_and_done", 32'd1, 32'd0);
        if (busy4 && done4) chk("k4_busy_and_done", 32'd1, 32'd0);
    end

    // Called right after a falling edge; pulses start and checks the stall/done
    // timeline of the chosen instance against a literal latency and result.
    task automatic run_op(input string name, input int which, input logic [31:0] rm,
                          input logic [11:0] op, input logic im, input logic ls,
                          input int lat, input logic [31:0] exp);
        val_rm = rm; shift_operand = op; imm = im; ldr_or_str = ls; start = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk({name, "_busy"}, {31'b0, (which == 4) ? busy4 : busy1}, {31'b0, k < lat});
            chk({name, "_done"}, {31'b0, (which == 4) ? done4 : done1}, {31'b0, k == lat});
        end
        chk({name, "_val2"}, (which == 4) ? val24 : val21, exp);
    endtask

    task automatic settle();
        start = 1'b0; flush = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; imm = 1'b0; ldr_or_str = 1'b0;
        val_rm = '0; shift_operand = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_done", {31'b0, done1}, 32'd0);
        chk("rst_val2", val21, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("imm_ror_k1", 1, 32'h0, 12'h2FF, 1'b1, 1'b0, 5, 32'hF000000F);
        settle();
        run_op("mem_off", 1, 32'h0, 12'hFFC, 1'b1, 1'b1, 1, 32'hFFFFFFFC);
        settle();
        run_op("asr_k1", 1, 32'h80000010, 12'h240, 1'b0, 1'b0, 5, 32'hF8000001);
        settle();
        run_op("lsr31_k4", 4, 32'hFFFFFFFF, 12'hFA0, 1'b0, 1'b0, 9, 32'h00000001);
        settle();

        // Back-to-back LSL #0 with start held through the DONE cycle.
        val_rm = 32'h12345678; shift_operand = 12'h000; imm = 1'b0; ldr_or_str = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("b2b_first_done", {31'b0, done1}, 32'd1);
        chk("b2b_first_val2", val21, 32'h12345678);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_done", {31'b0, done1}, 32'd1);
        chk("b2b_second_val2", val21, 32'h12345678);
        @(negedge clk);
        chk("b2b_after_done", {31'b0, done1}, 32'd0);
        settle();

        // Extra start during SHIFT must not create another result.
        val_rm = 32'hDEADBEEF; shift_operand = 12'h400; start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (done1) ndone++;
        end
        chk("shift_start_ignored_dones", ndone, 1);
        settle();

        // Flush mid-ROR leaves val2 alone.
        run_op("preload", 1, 32'hA5A5A5A5, 12'h000, 1'b0, 1'b0, 1, 32'hA5A5A5A5);
        settle();
        val_rm = 32'h0F0F1234; shift_operand = 12'hFE0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_busy", {31'b0, busy1}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 35; k++) begin
            if (done1) ndone++;
            @(negedge clk);
        end
        chk("flush_no_done", ndone, 0);
        chk("flush_val2_kept", val21, 32'hA5A5A5A5);
        run_op("post_flush", 1, 32'h000000F0, 12'h220, 1'b0, 1'b0, 5, 32'h0000000F);
        settle();

        // Asynchronous reset between edges during SHIFT.
        val_rm = 32'h13579BDF; shift_operand = 12'hFE0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_busy", {31'b0, busy1}, 32'd0);
        chk("areset_done", {31'b0, done1}, 32'd0);
        chk("areset_val2", val21, 32'h0);
        chk("areset_val2_k4", val24, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done1 || done4) ndone++;
        end
        chk("areset_no_done", ndone, 0);

        // Randomized traffic, checked by the per-cycle compare.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 24) == 0);
            ldr_or_str = ($urandom_range(0, 5) == 0);
            imm = ($urandom_range(0, 2) == 0);
            shift_operand = 12'($urandom);
            case ($urandom_range(0, 3))
                0: val_rm = 32'h80000000 | 32'($urandom_range(0, 255));
                1: val_rm = 32'hFFFFFFFF;
                default: val_rm = $urandom;
            endcase
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
